// File: rtl/millennium_pkg.sv
// Constants and types shared by the year counter and the year BCD loader.
package millennium_pkg;

  localparam int unsigned YEAR_MIN   = 2025;
  localparam int unsigned YEAR_MAX   = 2999;
  localparam int unsigned YEAR_RESET = 2025;
  localparam logic [15:0] YEAR_RESET_BCD = 16'h2025;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    IDLE,
    EDIT,
    CONV,
    CHECK,
    LOAD
  } state_t;

  // acc*10 + digit; 14 bits are needed because 9999 does not fit in 12
  function automatic logic [13:0] mul10_add(input logic [13:0] a, input bcd_t d);
    return (a << 3) + (a << 1) + {10'd0, d};
  endfunction

endpackage

// File: rtl/bcd_digit_editor.sv
// One editable BCD digit: parallel load, wrap-around increment and decrement.
module bcd_digit_editor
  import millennium_pkg::*;
#(
  parameter bcd_t RST_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc_en,
  input  logic       dec_en,
  output logic [3:0] digit
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      digit <= RST_VAL;
    end else if (load) begin
      digit <= load_val;
    end else if (inc_en && !dec_en) begin
      digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end else if (dec_en && !inc_en) begin
      digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/year_bcd_loader.sv
// Lets the user edit the year as four BCD digits, converts to binary, range
// checks it and offers it to the year counter with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start_edit, digits hold
// EDIT  | user adjusts the selected digit
// CONV  | four acc = acc*10 + digit steps, thousands first
// CHECK | range check of the converted year
// LOAD  | year_out offered, waiting for load_ready
module year_bcd_loader
  import millennium_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  cur_thousands,
  input  logic [3:0]  cur_hundreds,
  input  logic [3:0]  cur_tens,
  input  logic [3:0]  cur_units,
  input  logic        start_edit,
  input  logic        next_digit,
  input  logic        inc,
  input  logic        dec,
  input  logic        confirm,
  input  logic        abort,
  input  logic        load_ready,
  output logic [11:0] year_out,
  output logic        load_valid,
  output logic [3:0]  edit_d3,
  output logic [3:0]  edit_d2,
  output logic [3:0]  edit_d1,
  output logic [3:0]  edit_d0,
  output logic [1:0]  digit_sel,
  output logic        editing,
  output logic        err
);

  state_t      state, next_state;
  logic [13:0] acc;
  logic [1:0]  step;
  logic [1:0]  sel;
  logic [11:0] year_q;
  logic        err_q;
  bcd_t        digits   [4];
  bcd_t        cur      [4];
  logic        in_range;
  logic        edit_ok, sel_adv, digit_op, load_digits;

  assign cur[3] = cur_thousands;
  assign cur[2] = cur_hundreds;
  assign cur[1] = cur_tens;
  assign cur[0] = cur_units;

  assign in_range    = (acc >= 14'(YEAR_MIN)) && (acc <= 14'(YEAR_MAX));
  assign load_digits = (state == IDLE) && start_edit;
  assign edit_ok     = (state == EDIT) && !abort && !confirm;
  assign sel_adv     = edit_ok && next_digit;
  assign digit_op    = edit_ok && !next_digit;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit_editor #(
      .RST_VAL(YEAR_RESET_BCD[4*i +: 4])
    ) u_digit (
      .clk     (clk),
      .rstn    (rstn),
      .load    (load_digits),
      .load_val(cur[i]),
      .inc_en  (digit_op && inc && (sel == 2'(i))),
      .dec_en  (digit_op && dec && (sel == 2'(i))),
      .digit   (digits[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_valid = 1'b0;
    editing    = 1'b0;
    case (state)
      IDLE:  if (start_edit) next_state = EDIT;
      EDIT: begin
        editing = 1'b1;
        if (abort)        next_state = IDLE;
        else if (confirm) next_state = CONV;
      end
      CONV:  if (step == 2'd3) next_state = CHECK;
      CHECK: next_state = in_range ? LOAD : EDIT;
      LOAD: begin
        load_valid = 1'b1;
        if (load_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc    <= '0;
      step   <= '0;
      sel    <= 2'd3;
      year_q <= 12'(YEAR_RESET);
      err_q  <= 1'b0;
    end else begin
      err_q <= (state == CHECK) && !in_range;
      if (load_digits) sel <= 2'd3;
      if (sel_adv) sel <= sel - 2'd1;
      if (edit_ok == 1'b0 && state == EDIT && !abort) begin
        acc  <= '0;
        step <= '0;
      end
      if (state == CONV) begin
        acc  <= mul10_add(acc, digits[~step]);
        step <= step + 2'd1;
      end
      if (state == CHECK) begin
        if (in_range) year_q <= acc[11:0];
        else          sel    <= 2'd3;
      end
    end
  end

  assign year_out  = year_q;
  assign err       = err_q;
  assign digit_sel = sel;
  assign edit_d3   = digits[3];
  assign edit_d2   = digits[2];
  assign edit_d1   = digits[1];
  assign edit_d0   = digits[0];

endmodule

// File: tb/tb_year_bcd_loader.sv
// Scoreboard bench for year_bcd_loader: expected loads/rejections are queued
// when confirm is driven and matched when load handshakes or err appear.
module tb_year_bcd_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  cur_thousands = 4'd2, cur_hundreds = 4'd0, cur_tens = 4'd2, cur_units = 4'd5;
  logic        start_edit = 0, next_digit = 0, inc = 0, dec = 0, confirm = 0, abort = 0;
  logic        load_ready = 0;
  logic [11:0] year_out;
  logic        load_valid;
  logic [3:0]  edit_d3, edit_d2, edit_d1, edit_d0;
  logic [1:0]  digit_sel;
  logic        editing;
  logic        err;

  localparam logic [5:0] P_ABORT = 6'b100000;
  localparam logic [5:0] P_CONF  = 6'b010000;
  localparam logic [5:0] P_START = 6'b001000;
  localparam logic [5:0] P_NEXT  = 6'b000100;
  localparam logic [5:0] P_INC   = 6'b000010;
  localparam logic [5:0] P_DEC   = 6'b000001;
  localparam int ERR_TOKEN = -1;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int popped;

  year_bcd_loader dut (
    .clk(clk), .rstn(rstn),
    .cur_thousands(cur_thousands), .cur_hundreds(cur_hundreds),
    .cur_tens(cur_tens), .cur_units(cur_units),
    .start_edit(start_edit), .next_digit(next_digit), .inc(inc), .dec(dec),
    .confirm(confirm), .abort(abort), .load_ready(load_ready),
    .year_out(year_out), .load_valid(load_valid),
    .edit_d3(edit_d3), .edit_d2(edit_d2), .edit_d1(edit_d1), .edit_d0(edit_d0),
    .digit_sel(digit_sel), .editing(editing), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int expect_for(input logic [15:0] b);
    int y;
    y = int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    return (y >= 2025 && y <= 2999) ? y : ERR_TOKEN;
  endfunction

  function automatic int digits_now();
    return int'({edit_d3, edit_d2, edit_d1, edit_d0});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [5:0] m);
    {abort, confirm, start_edit, next_digit, inc, dec} = m;
    tick();
    {abort, confirm, start_edit, next_digit, inc, dec} = 6'b0;
  endtask

  task automatic set_cur(input logic [15:0] b);
    {cur_thousands, cur_hundreds, cur_tens, cur_units} = b;
  endtask

  // confirm at E0, then E1..E5; load_valid must stay low until after E5
  task automatic confirm_and_convert();
    pulse(P_CONF);
    for (int k = 0; k < 5; k++) begin
      check_eq("lv_early", int'(load_valid), 0);
      tick();
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rstn) begin
      if (load_valid && load_ready) begin
        if (exp_q.size() == 0) check_eq("sb_spurious_load", exp_q.size(), 1);
        else begin
          popped = exp_q.pop_front();
          check_eq("sb_load_year", int'(year_out), popped);
        end
      end
      if (err) begin
        if (exp_q.size() == 0) check_eq("sb_spurious_err", exp_q.size(), 1);
        else begin
          popped = exp_q.pop_front();
          check_eq("sb_err", ERR_TOKEN, popped);
        end
      end
    end
  end

  initial begin
    // reset values
    #12;
    check_eq("rst_lv", int'(load_valid), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_year", int'(year_out), 2025);
    check_eq("rst_digits", digits_now(), 'h2025);
    check_eq("rst_sel", int'(digit_sel), 3);
    check_eq("rst_editing", int'(editing), 0);
    #5 rstn = 1'b1;
    tick();

    // edit hundreds to 3 -> 2325, immediate handshake
    set_cur(16'h2025);
    pulse(P_START);
    check_eq("start_editing", int'(editing), 1);
    check_eq("start_sel", int'(digit_sel), 3);
    pulse(P_NEXT);
    check_eq("next_sel", int'(digit_sel), 2);
    repeat (3) pulse(P_INC);
    check_eq("inc_digits", digits_now(), 'h2325);
    exp_q.push_back(expect_for(16'h2325));
    load_ready = 1'b1;
    confirm_and_convert();
    check_eq("t1_lv", int'(load_valid), 1);
    check_eq("t1_year", int'(year_out), 2325);
    tick();
    check_eq("t1_lv_off", int'(load_valid), 0);
    check_eq("t1_idle", int'(editing), 0);

    // digit wrap on units and priority
    set_cur(16'h2020);
    pulse(P_START);
    repeat (3) pulse(P_NEXT);
    check_eq("wrap_sel", int'(digit_sel), 0);
    pulse(P_DEC);
    check_eq("wrap_dec", digits_now(), 'h2029);
    pulse(P_INC);
    check_eq("wrap_inc", digits_now(), 'h2020);
    pulse(P_INC | P_DEC);
    check_eq("wrap_both", digits_now(), 'h2020);
    pulse(P_NEXT | P_INC);
    check_eq("pri_next_sel", int'(digit_sel), 3);
    check_eq("pri_next_dig", digits_now(), 'h2020);
    pulse(P_ABORT | P_CONF);
    check_eq("pri_abort", int'(editing), 0);
    check_eq("abort_hold", digits_now(), 'h2020);
    repeat (6) tick();
    check_eq("abort_no_lv", int'(load_valid), 0);

    // IDLE ignores everything except start_edit
    pulse(P_INC | P_NEXT | P_CONF | P_DEC);
    check_eq("idle_ign_dig", digits_now(), 'h2020);
    check_eq("idle_ign_state", int'(editing), 0);

    // out of range below and above
    set_cur(16'h2024);
    pulse(P_START);
    exp_q.push_back(expect_for(16'h2024));
    confirm_and_convert();
    check_eq("lo_err", int'(err), 1);
    check_eq("lo_edit", int'(editing), 1);
    check_eq("lo_sel", int'(digit_sel), 3);
    check_eq("lo_digits", digits_now(), 'h2024);
    tick();
    check_eq("lo_err_off", int'(err), 0);
    check_eq("lo_lv", int'(load_valid), 0);
    pulse(P_ABORT);
    set_cur(16'h3000);
    pulse(P_START);
    exp_q.push_back(expect_for(16'h3000));
    confirm_and_convert();
    check_eq("hi_err", int'(err), 1);
    check_eq("hi_edit", int'(editing), 1);
    tick();
    pulse(P_ABORT);

    // lower boundary accepted
    set_cur(16'h2025);
    pulse(P_START);
    exp_q.push_back(expect_for(16'h2025));
    confirm_and_convert();
    check_eq("min_lv", int'(load_valid), 1);
    check_eq("min_year", int'(year_out), 2025);
    tick();

    // upper boundary with held handshake; edit pulses ignored in LOAD
    load_ready = 1'b0;
    set_cur(16'h2999);
    pulse(P_START);
    exp_q.push_back(expect_for(16'h2999));
    confirm_and_convert();
    for (int k = 0; k < 7; k++) begin
      check_eq("hold_lv", int'(load_valid), 1);
      check_eq("hold_year", int'(year_out), 2999);
      if (k == 3) pulse(P_ABORT | P_START);
      else tick();
    end
    load_ready = 1'b1;
    tick();
    check_eq("hold_lv_off", int'(load_valid), 0);
    check_eq("hold_idle", int'(editing), 0);
    check_eq("hold_year_kept", int'(year_out), 2999);

    // asynchronous reset in the middle of CONV
    set_cur(16'h2500);
    pulse(P_START);
    pulse(P_CONF);
    repeat (2) tick();
    #2 rstn = 1'b0;
    #1;
    check_eq("arst_lv", int'(load_valid), 0);
    check_eq("arst_err", int'(err), 0);
    check_eq("arst_year", int'(year_out), 2025);
    check_eq("arst_digits", digits_now(), 'h2025);
    check_eq("arst_sel", int'(digit_sel), 3);
    check_eq("arst_editing", int'(editing), 0);
    #3 rstn = 1'b1;
    repeat (8) tick();
    check_eq("post_rst_lv", int'(load_valid), 0);
    check_eq("post_rst_idle", int'(editing), 0);

    check_eq("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
